// File: rtl/stoch_decorr_pkg.sv
// Shared helpers for the stochastic decorrelator: window length and the
// per-channel low-discrepancy sequence (bit-reversed position XOR channel id).
package stoch_decorr_pkg;

  function automatic int unsigned win_len(input int unsigned w);
    return 32'd1 << w;
  endfunction

  function automatic logic [31:0] bitrev(input logic [31:0] v, input int unsigned w);
    logic [31:0] r;
    r = 32'd0;
    // Shift bits in LSB-first so that after w steps v[0] lands at r[w-1].
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < w) begin
        r = {r[30:0], v[i[4:0]]};
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] seq_val(input logic [31:0] pos, input logic [31:0] ch,
                                          input int unsigned w);
    logic [31:0] mask;
    mask = win_len(w) - 32'd1;
    return bitrev(pos, w) ^ (ch & mask);
  endfunction

endpackage

// File: rtl/stoch_decorrelator_mc_if.sv
// Stream bus of the stochastic decorrelator. Optional clr exists only when
// STOCH_DECORR_CLEAR_EN is defined.
interface stoch_decorrelator_mc_if #(
  parameter int WIDTH    = 5,
  parameter int CHANNELS = 4
);
  logic                            in_valid;
  logic [CHANNELS-1:0]             in_bits;
  logic                            out_valid;
  logic [CHANNELS-1:0]             out_bits;
  logic [CHANNELS*(WIDTH+1)-1:0]   count_o;
  logic                            window_done;
`ifdef STOCH_DECORR_CLEAR_EN
  logic                            clr;
`endif

  modport master (
`ifdef STOCH_DECORR_CLEAR_EN
    output clr,
`endif
    output in_valid, in_bits,
    input  out_valid, out_bits, count_o, window_done
  );

  modport slave (
`ifdef STOCH_DECORR_CLEAR_EN
    input  clr,
`endif
    input  in_valid, in_bits,
    output out_valid, out_bits, count_o, window_done
  );
endinterface

// File: rtl/stoch_decorr_channel.sv
// One decorrelator lane: ones counter, window snapshot and regeneration
// comparator against this channel's sequence value.
module stoch_decorr_channel
  import stoch_decorr_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int CH    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             accept_i,
  input  logic             clear_i,
  input  logic             boundary_i,
  input  logic             primed_i,
  input  logic [WIDTH-1:0] pos_i,
  input  logic             bit_i,
  output logic             out_bit_o,
  output logic [WIDTH:0]   snap_o
);

  logic [WIDTH:0]   cnt_q, cnt_d;
  logic [WIDTH:0]   snap_q, snap_d;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] seq_s;
  logic             out_bit_q, out_bit_d;

  // Next-state: count, snapshot at the boundary, regenerate from the old snapshot.
  always_comb begin
    seq_s     = WIDTH'(seq_val(32'(pos_i), 32'(CH), WIDTH));
    sum_s     = cnt_q + {{WIDTH{1'b0}}, bit_i};
    cnt_d     = cnt_q;
    snap_d    = snap_q;
    out_bit_d = out_bit_q;
    if (clear_i) begin
      cnt_d = {(WIDTH+1){1'b0}};
    end else if (accept_i) begin
      if (boundary_i) begin
        cnt_d  = {(WIDTH+1){1'b0}};
        snap_d = sum_s;
      end else begin
        cnt_d  = sum_s;
      end
      if (primed_i) begin
        out_bit_d = ({1'b0, seq_s} < snap_q);
      end else begin
        out_bit_d = out_bit_q;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= {(WIDTH+1){1'b0}};
      snap_q    <= {(WIDTH+1){1'b0}};
      out_bit_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      snap_q    <= snap_d;
      out_bit_q <= out_bit_d;
    end
  end

  assign out_bit_o = out_bit_q;
  assign snap_o    = snap_q;

endmodule

// File: rtl/stoch_decorrelator_mc.sv
// Multi-channel stochastic bitstream decorrelator top: shared window position,
// priming and handshake. Optional synchronous clear: STOCH_DECORR_CLEAR_EN.
module stoch_decorrelator_mc
  import stoch_decorr_pkg::*;
#(
  parameter int WIDTH    = 5,
  parameter int CHANNELS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  stoch_decorrelator_mc_if.slave bus
);

  localparam int unsigned      L        = win_len(WIDTH);
  localparam logic [WIDTH-1:0] POS_LAST = WIDTH'(L - 32'd1);

  logic [WIDTH-1:0]              pos_q, pos_d;
  logic                          primed_q, primed_d;
  logic                          out_valid_q, out_valid_d;
  logic                          window_done_q, window_done_d;
  logic                          clear_s, accept_s, boundary_s;
  logic [CHANNELS-1:0]           out_bits_s;
  logic [CHANNELS*(WIDTH+1)-1:0] count_s;

`ifdef STOCH_DECORR_CLEAR_EN
  assign clear_s = bus.clr;
`else
  assign clear_s = 1'b0;
`endif

  // Clear wins over a presented bit, which is then simply dropped.
  assign accept_s   = bus.in_valid & ~clear_s;
  assign boundary_s = accept_s & (pos_q == POS_LAST);

  // Next-state for the shared window position and handshake flags.
  always_comb begin
    pos_d         = pos_q;
    primed_d      = primed_q;
    out_valid_d   = 1'b0;
    window_done_d = 1'b0;
    if (clear_s) begin
      pos_d    = {WIDTH{1'b0}};
      primed_d = 1'b0;
    end else if (accept_s) begin
      pos_d         = pos_q + {{(WIDTH-1){1'b0}}, 1'b1};
      primed_d      = primed_q | boundary_s;
      out_valid_d   = primed_q;
      window_done_d = boundary_s;
    end else begin
      pos_d = pos_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q         <= {WIDTH{1'b0}};
      primed_q      <= 1'b0;
      out_valid_q   <= 1'b0;
      window_done_q <= 1'b0;
    end else begin
      pos_q         <= pos_d;
      primed_q      <= primed_d;
      out_valid_q   <= out_valid_d;
      window_done_q <= window_done_d;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    stoch_decorr_channel #(
      .WIDTH (WIDTH),
      .CH    (c)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .accept_i   (accept_s),
      .clear_i    (clear_s),
      .boundary_i (boundary_s),
      .primed_i   (primed_q),
      .pos_i      (pos_q),
      .bit_i      (bus.in_bits[c]),
      .out_bit_o  (out_bits_s[c]),
      .snap_o     (count_s[c*(WIDTH+1) +: (WIDTH+1)])
    );
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_bits    = out_bits_s;
  assign bus.count_o     = count_s;
  assign bus.window_done = window_done_q;

endmodule

// File: tb/tb_stoch_decorrelator_mc.sv
// Directed bench for stoch_decorrelator_mc at WIDTH=3, CHANNELS=2 (L=8);
// the clear scenario is compiled in with STOCH_DECORR_CLEAR_EN.
module tb_stoch_decorrelator_mc;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  logic [1:0] last_bits;

  stoch_decorrelator_mc_if #(.WIDTH(3), .CHANNELS(2)) bus ();

  stoch_decorrelator_mc #(.WIDTH(3), .CHANNELS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic v, input logic [1:0] b);
    @(negedge clk);
    bus.in_valid = v;
    bus.in_bits  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_bits", 32'(bus.out_bits), 32'd0);
    chk("rst_count_o", 32'(bus.count_o), 32'd0);
    chk("rst_window_done", 32'(bus.window_done), 32'd0);
    last_bits = 2'b00;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Applies n accepted bits of a window; bit i of each vector is position i.
  task automatic run_window(input logic [7:0] in0, input logic [7:0] in1,
                            input logic [7:0] exp0, input logic [7:0] exp1,
                            input bit primed, input bit stalls, input int n);
    int k;
    for (int i = 0; i < n; i++) begin
      k = stalls ? int'($urandom_range(0, 2)) : 0;
      for (int s = 0; s < k; s++) begin
        step(1'b0, 2'($urandom_range(0, 3)));
        chk("stall_valid", 32'(bus.out_valid), 32'd0);
        chk("stall_hold", 32'(bus.out_bits), 32'(last_bits));
      end
      step(1'b1, {in1[i], in0[i]});
      if (primed) last_bits = {exp1[i], exp0[i]};
      chk("out_valid", 32'(bus.out_valid), 32'(primed));
      chk("out_bits", 32'(bus.out_bits), 32'(last_bits));
      chk("window_done", 32'(bus.window_done), 32'(i == 7));
    end
    if (n == 8) begin
      chk("count_o", 32'(bus.count_o), {24'd0, 4'($countones(in1)), 4'($countones(in0))});
    end
  endtask

  initial begin
    n_vec        = 0;
    n_err        = 0;
    last_bits    = 2'b00;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_bits  = 2'b00;
`ifdef STOCH_DECORR_CLEAR_EN
    bus.clr      = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("init_out_valid", 32'(bus.out_valid), 32'd0);
    chk("init_out_bits", 32'(bus.out_bits), 32'd0);
    chk("init_count_o", 32'(bus.count_o), 32'd0);
    chk("init_window_done", 32'(bus.window_done), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // All ones: snapshot 8 on both channels regenerates as all ones.
    run_window(8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 8);
    run_window(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0, 8);

    // Value 3 on ch0 (ones at positions 1,3,5): regenerated 1,0,1,0,1,0,0,0.
    reset_pulse();
    run_window(8'b0010_1010, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8);
    run_window(8'h00, 8'h00, 8'b0001_0101, 8'h00, 1'b1, 1'b0, 8);

    // Value 3 on ch1: XOR offset 1 gives 1,0,0,0,1,0,1,0.
    reset_pulse();
    run_window(8'h00, 8'b0000_0111, 8'h00, 8'h00, 1'b0, 1'b0, 8);
    run_window(8'h00, 8'h00, 8'h00, 8'b0101_0001, 1'b1, 1'b0, 8);

    // Value 3 on ch0 again, with random stalls between accepted bits.
    reset_pulse();
    run_window(8'b0010_1010, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8);
    run_window(8'h00, 8'h00, 8'b0001_0101, 8'h00, 1'b1, 1'b1, 8);

    // Reset three outputs into window 2: next full window yields no out_valid.
    reset_pulse();
    run_window(8'b0010_1010, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8);
    run_window(8'h00, 8'h00, 8'b0001_0101, 8'h00, 1'b1, 1'b0, 3);
    reset_pulse();
    run_window(8'hFF, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8);

`ifdef STOCH_DECORR_CLEAR_EN
    // Clear at pos 5 drops that bit; a fresh window then starts from pos 0.
    reset_pulse();
    run_window(8'b0010_1010, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8);
    run_window(8'h00, 8'h00, 8'b0001_0101, 8'h00, 1'b1, 1'b0, 5);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_bits  = 2'b11;
    bus.clr      = 1'b1;
    @(posedge clk);
    #1;
    chk("clr_out_valid", 32'(bus.out_valid), 32'd0);
    chk("clr_out_bits", 32'(bus.out_bits), 32'(last_bits));
    chk("clr_count_o", 32'(bus.count_o), 32'h03);
    chk("clr_window_done", 32'(bus.window_done), 32'd0);
    @(negedge clk);
    bus.clr = 1'b0;
    run_window(8'hFF, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 7);
    chk("clr_count_hold", 32'(bus.count_o), 32'h03);
    step(1'b1, 2'b01);
    chk("clr_fresh_done", 32'(bus.window_done), 32'd1);
    chk("clr_fresh_count", 32'(bus.count_o), 32'h08);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
